// File: rtl/regfile_sweep_if.sv
// regfile_sweep_if: write, read and sweep-clear bus of regfile_sweep
interface regfile_sweep_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic                    we;
    logic [ADDR_W-1:0]       wa;
    logic [WIDTH-1:0]        wd;
    logic [NREAD*ADDR_W-1:0] ra;
    logic [NREAD*WIDTH-1:0]  rd;
    logic                    clr_req;
    logic                    busy;
    logic                    clr_done;

    modport master(output we, wa, wd, ra, clr_req, input rd, busy, clr_done);
    modport slave(input we, wa, wd, ra, clr_req, output rd, busy, clr_done);
endinterface

// File: rtl/regfile_sweep.sv
// regfile_sweep: multi-read register file with a hardware sweep-clear FSM
// Optional write-to-read bypass enabled by defining REGFILE_SWEEP_BYPASS_EN.
module regfile_sweep #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input logic             clk,
    input logic             rst_n,
    regfile_sweep_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wr_ok;

    assign wr_ok = state == IDLE && bus.we && bus.wa != '0;

    // Sweep FSM: IDLE -> SWEEP (zero regs 1..DEPTH-1) -> DONE -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.clr_req) begin
                    state    <= SWEEP;
                    cnt      <= ADDR_W'(1);
                    bus.busy <= 1'b1;
                end
                SWEEP: if (cnt == LAST) begin
                    state        <= DONE;
                    bus.clr_done <= 1'b1;
                end else begin
                    cnt <= cnt + ADDR_W'(1);
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    bus.busy     <= 1'b0;
                    bus.clr_done <= 1'b0;
                end
            endcase
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_reg
        // Storage: external write only in IDLE, sweep zeroes the counter's register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mem[j] <= '0;
            else if (wr_ok && bus.wa == ADDR_W'(j))
                mem[j] <= bus.wd;
            else if (state == SWEEP && cnt == ADDR_W'(j))
                mem[j] <= '0;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  stored;
        assign a      = bus.ra[i*ADDR_W +: ADDR_W];
        assign stored = a == '0 ? '0 : mem[a];
`ifdef REGFILE_SWEEP_BYPASS_EN
        assign bus.rd[i*WIDTH +: WIDTH] = (wr_ok && a == bus.wa) ? bus.wd : stored;
`else
        assign bus.rd[i*WIDTH +: WIDTH] = stored;
`endif
    end
endmodule

// File: tb/tb_regfile_sweep.sv
// tb_regfile_sweep: randomized and directed checks of regfile_sweep against a behavioural model
`timescale 1ns/1ps
module tb_regfile_sweep;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sweep_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus();
    regfile_sweep #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREAD(NREAD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int left;
    int idx;
    int busy_cnt;
    int done_cnt;
    int done_at;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(logic [ADDR_W-1:0] a);
`ifdef REGFILE_SWEEP_BYPASS_EN
        if (left == 0 && bus.we && bus.wa != 0 && a == bus.wa) return bus.wd;
`endif
        return ref_mem[a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        left = 0;
        idx  = 0;
    endtask

    task automatic model_step();
        if (left == 0) begin
            if (bus.we && bus.wa != 0) ref_mem[bus.wa] = bus.wd;
            if (bus.clr_req) begin
                left = DEPTH;
                idx  = 1;
            end
        end else begin
            if (idx < DEPTH) begin
                ref_mem[idx] = '0;
                idx++;
            end
            left--;
        end
    endtask

    task automatic check_outs();
        for (int i = 0; i < NREAD; i++)
            check($sformatf("rd%0d", i), bus.rd[i*WIDTH +: WIDTH], exp_rd(bus.ra[i*ADDR_W +: ADDR_W]));
        check("busy", bus.busy, left > 0);
        check("clr_done", bus.clr_done, left == 1);
        if (bus.busy) busy_cnt++;
        if (bus.clr_done) begin
            done_cnt++;
            done_at = busy_cnt;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outs();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic drive(logic w, logic [ADDR_W-1:0] a, logic [WIDTH-1:0] d,
                         logic [ADDR_W-1:0] r0, logic [ADDR_W-1:0] r1, logic c);
        bus.we      = w;
        bus.wa      = a;
        bus.wd      = d;
        bus.ra      = {r1, r0};
        bus.clr_req = c;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic peek_all();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, '0, ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), 1'b0);
            tick();
        end
    endtask

    task automatic clear_counts();
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
    endtask

    task automatic sweep_counts(string tag);
        check({tag, "_busy_cycles"}, busy_cnt, DEPTH);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, DEPTH);
    endtask

    initial begin
        model_reset();
        clear_counts();
        idle();
        #12;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.clr_done, 0);
        check("reset_rd", bus.rd, 0);
        rst_n = 1'b1;
        tick();

        // basic write and read, register 0 stays zero
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0);
        tick();
        drive(1'b1, 5'd0, 32'h1, 5'd5, 5'd5, 1'b0);
        #1;
        check("rd0_reg5", bus.rd[WIDTH-1:0], 32'hDEADBEEF);
        check("rd1_reg5", bus.rd[2*WIDTH-1:WIDTH], 32'hDEADBEEF);
        tick();
        drive(1'b0, '0, '0, 5'd0, 5'd0, 1'b0);
        #1;
        check("reg0_zero", bus.rd[WIDTH-1:0], 0);
        tick();

        // fill then full sweep
        for (int a = 1; a < DEPTH; a++) begin
            drive(1'b1, ADDR_W'(a), WIDTH'(a), ADDR_W'(a), ADDR_W'(a - 1), 1'b0);
            tick();
        end
        peek_all();
        clear_counts();
        drive(1'b0, '0, '0, 5'd31, 5'd1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 5'd31, 5'd1, 1'b0);
        repeat (40) tick();
        sweep_counts("sweep");
        peek_all();

        // write and clr_req during sweep are ignored
        drive(1'b1, 5'd3, 32'h99, 5'd3, 5'd3, 1'b0);
        tick();
        clear_counts();
        drive(1'b0, '0, '0, 5'd3, 5'd20, 1'b1);
        tick();
        idle();
        repeat (9) tick();
        drive(1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b1);
        tick();
        idle();
        repeat (35) tick();
        sweep_counts("ignore");
        drive(1'b0, '0, '0, 5'd3, 5'd3, 1'b0);
        #1;
        check("w_dropped", bus.rd[WIDTH-1:0], 0);
        tick();

        // reset in the middle of a sweep
        for (int a = 1; a < DEPTH; a++) begin
            drive(1'b1, ADDR_W'(a), WIDTH'(a * 7), '0, '0, 1'b0);
            tick();
        end
        clear_counts();
        drive(1'b0, '0, '0, 5'd20, 5'd30, 1'b1);
        tick();
        drive(1'b0, '0, '0, 5'd20, 5'd30, 1'b0);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.clr_done, 0);
        check("abort_rd", bus.rd, 0);
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        clear_counts();
        repeat (40) tick();
        check("abort_no_done", done_cnt, 0);
        peek_all();

        // same-cycle read of a register being written
        drive(1'b1, 5'd9, 32'hAAAA, 5'd9, 5'd9, 1'b0);
        tick();
        drive(1'b1, 5'd9, 32'h1234, 5'd9, 5'd2, 1'b0);
        #1;
`ifdef REGFILE_SWEEP_BYPASS_EN
        check("bypass", bus.rd[WIDTH-1:0], 32'h1234);
`else
        check("no_bypass", bus.rd[WIDTH-1:0], 32'hAAAA);
`endif
        tick();

        // write and clr_req together in IDLE
        clear_counts();
        drive(1'b1, 5'd4, 32'h77, 5'd4, 5'd9, 1'b1);
        tick();
        drive(1'b0, '0, '0, 5'd4, 5'd9, 1'b0);
        #1;
        check("wr_clr_reg4", bus.rd[WIDTH-1:0], 32'h77);
        repeat (40) tick();
        sweep_counts("wr_clr");

        // random traffic
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom), ADDR_W'($urandom), WIDTH'($urandom),
                  ADDR_W'($urandom), ADDR_W'($urandom), ($urandom % 40) == 0);
            tick();
        end
        idle();
        repeat (40) tick();
        peek_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
